// File: rtl/posit_mul_pkg.sv
// Shared constants, phase encoding and helpers for the bit-serial posit x FP16 multiplier.
package posit_mul_pkg;

  localparam int unsigned LANES_DEF     = 4;
  localparam int unsigned EXP_WIDTH_DEF = 5;
  localparam int unsigned MAN_WIDTH_DEF = 10;
  localparam int unsigned MAX_N_DEF     = 16;

  localparam int unsigned F         = MAX_N_DEF - 3;
  localparam int unsigned MANT_W    = 2 + MAN_WIDTH_DEF + F;
  localparam int unsigned EXPO_W    = EXP_WIDTH_DEF + 4;
  localparam int unsigned FP16_BIAS = 15;

  typedef enum logic [1:0] {PhSign, PhRegime, PhExp, PhFrac} phase_e;

  // Posit widths below 3 leave no room for sign plus a terminated regime.
  function automatic logic [4:0] clamp_prec(input logic [4:0] p, input int unsigned max_n);
    if (p < 5'd3) begin
      return 5'd3;
    end else if (p > 5'(max_n)) begin
      return 5'(max_n);
    end
    return p;
  endfunction

endpackage

// File: rtl/posit_serial_lane.sv
// One lane: decodes a serial sign-magnitude posit weight and forms the exact product with an
// FP16 activation latched on the first bit of the frame.
module posit_serial_lane
  import posit_mul_pkg::*;
#(
  parameter int unsigned ACT_WIDTH = 16,
  parameter int unsigned EXP_WIDTH = 5,
  parameter int unsigned MAN_WIDTH = 10,
  parameter int unsigned MAX_N     = 16,
  parameter int unsigned ES        = 0
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 adv,
  input  logic                                 first,
  input  logic                                 last,
  input  logic                                 w,
  input  logic [ACT_WIDTH-1:0]                 act,
  output logic                                 sign_out,
  output logic [EXP_WIDTH+3:0]                 exp_out,
  output logic [2+MAN_WIDTH+MAX_N-3-1:0]       mant_out,
  output logic                                 zero_out,
  output logic                                 nar_out,
  output logic                                 nan_out
);

  localparam int unsigned FracW = MAX_N - 3;
  localparam int unsigned MantW = 2 + MAN_WIDTH + FracW;
  localparam int unsigned ExpoW = EXP_WIDTH + 4;
  localparam int unsigned EW    = (ES > 0) ? ES : 1;
  localparam int unsigned RW    = $clog2(MAX_N + 1);

  phase_e               phase_q, phase_d;
  logic                 s_q, s_d;
  logic                 w0_q, w0_d;
  logic                 nz_q, nz_d;
  logic                 b_q, b_d;
  logic [RW-1:0]        run_q, run_d;
  logic [EW-1:0]        e_q, e_d;
  logic [1:0]           ecnt_q, ecnt_d;
  logic [RW-1:0]        j_q, j_d;
  logic [EXP_WIDTH-1:0] aexp_q, aexp_d;
  logic [MAN_WIDTH-1:0] aman_q, aman_d;
  logic [MantW-1:0]     mant_q, mant_d;
  logic [MantW-1:0]     mant_init;

  logic [1:0]              shamt;
  logic [EW-1:0]           e_fin;
  logic signed [ExpoW-1:0] k_s;
  logic [ExpoW-1:0]        exp_s;
  logic                    f_zero, f_nar, f_nan, f_any;

  assign mant_init = {2'b01, aman_q, {FracW{1'b0}}};

  always_comb begin
    phase_d = phase_q;
    s_d     = s_q;
    w0_d    = w0_q;
    nz_d    = nz_q;
    b_d     = b_q;
    run_d   = run_q;
    e_d     = e_q;
    ecnt_d  = ecnt_q;
    j_d     = j_q;
    aexp_d  = aexp_q;
    aman_d  = aman_q;
    mant_d  = mant_q;
    if (adv) begin
      if (first) begin
        s_d     = w ^ act[ACT_WIDTH-1];
        w0_d    = w;
        nz_d    = 1'b0;
        b_d     = 1'b0;
        run_d   = '0;
        e_d     = '0;
        ecnt_d  = '0;
        j_d     = '0;
        aexp_d  = act[ACT_WIDTH-2 -: EXP_WIDTH];
        aman_d  = act[MAN_WIDTH-1:0];
        mant_d  = {2'b01, act[MAN_WIDTH-1:0], {FracW{1'b0}}};
        phase_d = PhRegime;
      end else begin
        nz_d = nz_q | w;
        case (phase_q)
          PhRegime: begin
            if (run_q == '0) begin
              b_d   = w;
              run_d = RW'(1);
            end else if (w == b_q) begin
              run_d = run_q + RW'(1);
            end else begin
              phase_d = (ES > 0) ? PhExp : PhFrac;
            end
          end
          PhExp: begin
            e_d    = EW'({e_q, w});
            ecnt_d = ecnt_q + 2'd1;
            if (ecnt_q == 2'(ES - 1)) begin
              phase_d = PhFrac;
            end
          end
          PhFrac: begin
            j_d = j_q + RW'(1);
            if (w) begin
              mant_d = mant_q + (mant_init >> j_d);
            end
          end
          default: ;
        endcase
      end
      if (last) begin
        phase_d = PhSign;
      end
    end
  end

  // Exponent bits cut off by the end of the frame are implicit zeros on the right.
  always_comb begin
    shamt = 2'(ES) - ecnt_d;
    e_fin = e_d << shamt;
    k_s   = $signed(ExpoW'(run_d));
    if (b_d) begin
      k_s = k_s - ExpoW'(1);
    end else begin
      k_s = -k_s;
    end
    exp_s  = ExpoW'(aexp_d) + ExpoW'(k_s <<< ES) + ExpoW'(e_fin);
    f_nar  = ~nz_d & w0_d;
    f_nan  = &aexp_d;
    f_zero = ((~nz_d & ~w0_d) | (aexp_d == '0)) & ~f_nar & ~f_nan;
    f_any  = f_zero | f_nar | f_nan;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase_q <= PhSign;
      s_q     <= 1'b0;
      w0_q    <= 1'b0;
      nz_q    <= 1'b0;
      b_q     <= 1'b0;
      run_q   <= '0;
      e_q     <= '0;
      ecnt_q  <= '0;
      j_q     <= '0;
      aexp_q  <= '0;
      aman_q  <= '0;
      mant_q  <= '0;
    end else begin
      phase_q <= phase_d;
      s_q     <= s_d;
      w0_q    <= w0_d;
      nz_q    <= nz_d;
      b_q     <= b_d;
      run_q   <= run_d;
      e_q     <= e_d;
      ecnt_q  <= ecnt_d;
      j_q     <= j_d;
      aexp_q  <= aexp_d;
      aman_q  <= aman_d;
      mant_q  <= mant_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sign_out <= 1'b0;
      exp_out  <= '0;
      mant_out <= '0;
      zero_out <= 1'b0;
      nar_out  <= 1'b0;
      nan_out  <= 1'b0;
    end else if (adv && last) begin
      sign_out <= s_d;
      exp_out  <= f_any ? '0 : exp_s;
      mant_out <= f_any ? '0 : mant_d;
      zero_out <= f_zero;
      nar_out  <= f_nar;
      nan_out  <= f_nan;
    end
  end

endmodule

// File: rtl/posit_serial_mul_lanes.sv
// Multi-lane bit-serial posit x FP16 multiplier: shared precision, frame counter and handshake
// around LANES independent decode/multiply lanes.
module posit_serial_mul_lanes
  import posit_mul_pkg::*;
#(
  parameter int unsigned LANES     = LANES_DEF,
  parameter int unsigned ACT_WIDTH = 16,
  parameter int unsigned EXP_WIDTH = EXP_WIDTH_DEF,
  parameter int unsigned MAN_WIDTH = MAN_WIDTH_DEF,
  parameter int unsigned MAX_N     = MAX_N_DEF,
  parameter int unsigned ES        = 0
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      set,
  input  logic [4:0]                                precision,
  input  logic                                      in_valid,
  input  logic [LANES*ACT_WIDTH-1:0]                act,
  input  logic [LANES-1:0]                          w,
  output logic                                      busy,
  output logic                                      out_valid,
  output logic [LANES-1:0]                          sign_out,
  output logic [LANES*(EXP_WIDTH+4)-1:0]            exp_out,
  output logic [LANES*(2+MAN_WIDTH+MAX_N-3)-1:0]    mant_out,
  output logic [LANES-1:0]                          zero_out,
  output logic [LANES-1:0]                          nar_out,
  output logic [LANES-1:0]                          nan_out
);

  localparam int unsigned MantW = 2 + MAN_WIDTH + MAX_N - 3;
  localparam int unsigned ExpoW = EXP_WIDTH + 4;

  logic [4:0] prec_q, prec_d;
  logic [4:0] bitcnt_q, bitcnt_d;
  logic       busy_q, busy_d;
  logic       out_valid_q, out_valid_d;
  logic       first, last;

  assign first = (bitcnt_q == 5'd0);
  assign last  = (bitcnt_q == prec_q - 5'd1);

  always_comb begin
    prec_d      = prec_q;
    bitcnt_d    = bitcnt_q;
    busy_d      = busy_q;
    out_valid_d = in_valid & last;
    if (set && !busy_q) begin
      prec_d = clamp_prec(precision, MAX_N);
    end
    if (in_valid) begin
      bitcnt_d = last ? 5'd0 : bitcnt_q + 5'd1;
      busy_d   = ~last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prec_q      <= 5'(MAX_N);
      bitcnt_q    <= 5'd0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      prec_q      <= prec_d;
      bitcnt_q    <= bitcnt_d;
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    posit_serial_lane #(
      .ACT_WIDTH(ACT_WIDTH),
      .EXP_WIDTH(EXP_WIDTH),
      .MAN_WIDTH(MAN_WIDTH),
      .MAX_N    (MAX_N),
      .ES       (ES)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .adv     (in_valid),
      .first   (first),
      .last    (last),
      .w       (w[i]),
      .act     (act[i*ACT_WIDTH +: ACT_WIDTH]),
      .sign_out(sign_out[i]),
      .exp_out (exp_out[i*ExpoW +: ExpoW]),
      .mant_out(mant_out[i*MantW +: MantW]),
      .zero_out(zero_out[i]),
      .nar_out (nar_out[i]),
      .nan_out (nan_out[i])
    );
  end

endmodule

// File: tb/tb_posit_serial_mul_lanes.sv
// Scoreboard bench: a behavioural posit decoder predicts each lane result when a frame is
// driven; results are popped and compared when out_valid pulses.
module tb_posit_serial_mul_lanes;
  import posit_mul_pkg::*;

  localparam int unsigned L  = 4;
  localparam int unsigned ES = 0;

  typedef struct packed {
    logic              s;
    logic [EXPO_W-1:0] e;
    logic [MANT_W-1:0] m;
    logic              z;
    logic              nr;
    logic              nn;
  } res_t;

  typedef struct {
    res_t r[L];
    int   start;
    int   lat;
  } frame_t;

  logic                clk = 1'b0;
  logic                rst;
  logic                set;
  logic [4:0]          precision;
  logic                in_valid;
  logic [L*16-1:0]     act;
  logic [L-1:0]        w;
  logic                busy, out_valid;
  logic [L-1:0]        sign_out, zero_out, nar_out, nan_out;
  logic [L*EXPO_W-1:0] exp_out;
  logic [L*MANT_W-1:0] mant_out;

  int     cyc = 0;
  int     n_tests = 0;
  int     n_fail = 0;
  int     ov_cnt = 0;
  frame_t sb[$];

  posit_serial_mul_lanes #(
    .LANES(L), .ACT_WIDTH(16), .EXP_WIDTH(5), .MAN_WIDTH(10), .MAX_N(16), .ES(ES)
  ) dut (
    .clk(clk), .rst(rst), .set(set), .precision(precision), .in_valid(in_valid),
    .act(act), .w(w), .busy(busy), .out_valid(out_valid), .sign_out(sign_out),
    .exp_out(exp_out), .mant_out(mant_out), .zero_out(zero_out), .nar_out(nar_out),
    .nan_out(nan_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint got, input longint want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  // Whole-word reference decode of an n-bit weight held in wv[n-1:0], sign in wv[n-1].
  function automatic res_t model(input logic [15:0] a, input logic [15:0] wv, input int n);
    res_t   o;
    int     i, r, k, e, nf, aexp, ev;
    logic   b, nz;
    longint frac, init, mant;
    aexp = int'(a[14:10]);
    nz = 1'b0;
    for (int t = 0; t < n - 1; t++) nz = nz | wv[t];
    b = wv[n-2];
    r = 0;
    i = 1;
    while (i < n && wv[n-1-i] == b) begin
      r++;
      i++;
    end
    if (i < n) i++;
    k = b ? r - 1 : -r;
    e = 0;
    for (int t = 0; t < int'(ES); t++) begin
      e = e * 2 + ((i < n) ? int'(wv[n-1-i]) : 0);
      if (i < n) i++;
    end
    nf   = n - i;
    frac = longint'(wv) & ((longint'(1) << nf) - 1);
    init = (longint'(1) << (10 + F)) | (longint'(a[9:0]) << F);
    mant = (init * ((longint'(1) << nf) + frac)) >> nf;
    ev   = aexp + k * (1 << ES) + e;
    o.s  = wv[n-1] ^ a[15];
    o.nr = !nz && wv[n-1];
    o.nn = (aexp == 31);
    o.z  = !o.nr && !o.nn && ((!nz && !wv[n-1]) || aexp == 0);
    if (o.z || o.nr || o.nn) begin
      o.e = '0;
      o.m = '0;
    end else begin
      o.e = EXPO_W'(ev);
      o.m = MANT_W'(mant);
    end
    return o;
  endfunction

  task automatic send_frame(input int n, input logic [63:0] acts, input logic [63:0] ws,
                            input int stall_at, input int stall_len, input int set_at,
                            input logic [4:0] set_val);
    frame_t f;
    for (int l = 0; l < int'(L); l++) f.r[l] = model(acts[l*16 +: 16], ws[l*16 +: 16], n);
    f.start = cyc;
    f.lat   = n + ((stall_at >= 0 && stall_at < n) ? stall_len : 0);
    for (int i = 0; i < n; i++) begin
      if (i == stall_at) begin
        in_valid = 1'b0;
        repeat (stall_len) @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      act      = acts;
      for (int l = 0; l < int'(L); l++) w[l] = ws[l*16 + n - 1 - i];
      set = (i == set_at);
      if (i == set_at) precision = set_val;
      if (i == n - 1) sb.push_back(f);
      @(posedge clk);
      #1;
      set = 1'b0;
      if (i == 0) chk("busy_rise", longint'(busy), 1);
    end
    in_valid = 1'b0;
    chk("busy_fall", longint'(busy), 0);
  endtask

  task automatic set_prec(input logic [4:0] v);
    set       = 1'b1;
    precision = v;
    @(posedge clk);
    #1;
    set = 1'b0;
  endtask

  initial begin : monitor
    frame_t f;
    logic   prev_ov;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid) begin
        ov_cnt++;
        chk("ov_pulse", longint'(prev_ov), 0);
        if (sb.size() == 0) begin
          chk("spurious_ov", 1, 0);
        end else begin
          f = sb.pop_front();
          chk("latency", longint'(cyc - f.start), longint'(f.lat));
          for (int l = 0; l < int'(L); l++) begin
            chk($sformatf("L%0d_sign", l), longint'(sign_out[l]), longint'(f.r[l].s));
            chk($sformatf("L%0d_exp", l), longint'(exp_out[l*EXPO_W +: EXPO_W]),
                longint'(f.r[l].e));
            chk($sformatf("L%0d_mant", l), longint'(mant_out[l*MANT_W +: MANT_W]),
                longint'(f.r[l].m));
            chk($sformatf("L%0d_flags", l),
                longint'({zero_out[l], nar_out[l], nan_out[l]}),
                longint'({f.r[l].z, f.r[l].nr, f.r[l].nn}));
          end
        end
      end
      prev_ov = out_valid;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin : stim
    logic [63:0] ws, acts;
    int          snap;
    rst = 1'b0; set = 1'b0; precision = 5'd0; in_valid = 1'b0; act = '0; w = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_ov", longint'(out_valid), 0);
    chk("rst_sign", longint'(sign_out), 0);
    chk("rst_exp", longint'(exp_out[31:0]), 0);
    chk("rst_mant", longint'(mant_out[63:0]), 0);
    chk("rst_flags", longint'({zero_out, nar_out, nan_out}), 0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Precision out of reset is MAX_N = 16.
    send_frame(16, {4{16'h3C00}}, {16'h7FFF, 16'h2ABC, 16'h6123, 16'h4000}, -1, 0, -1, 5'd0);
    set_prec(5'd8);

    // Back-to-back frames covering nominal values and specials.
    send_frame(8, {4{16'h3C00}}, {16'h007F, 16'h0030, 16'h0060, 16'h0040}, -1, 0, -1, 5'd0);
    send_frame(8, {16'h0000, 16'h7C00, 16'hBE00, 16'h3E00},
               {16'h0040, 16'h0040, 16'h0050, 16'h0050}, -1, 0, -1, 5'd0);
    acts = {16'h3555, 16'h4500, 16'h3C00, 16'h3C00};
    ws   = {16'h002B, 16'h00C5, 16'h0080, 16'h0000};
    send_frame(8, acts, ws, -1, 0, -1, 5'd0);
    // Same frame with a 3-cycle stall mid-frame.
    send_frame(8, acts, ws, 4, 3, -1, 5'd0);

    // set while busy is ignored for this frame and the next.
    send_frame(8, acts, {16'h0057, 16'h0023, 16'h00E9, 16'h0061}, -1, 0, 3, 5'd12);
    send_frame(8, acts, {16'h0011, 16'h0066, 16'h0099, 16'h004C}, -1, 0, -1, 5'd0);

    set_prec(5'd12);
    for (int l = 0; l < int'(L); l++) ws[l*16 +: 16] = 16'($urandom);
    send_frame(12, {16'h4A31, 16'h3001, 16'hC400, 16'h3BFF}, ws, -1, 0, -1, 5'd0);

    set_prec(5'd1);
    send_frame(3, {16'h3C00, 16'h3C00, 16'h4400, 16'h3C00},
               {16'h0004, 16'h0001, 16'h0003, 16'h0002}, -1, 0, -1, 5'd0);

    set_prec(5'd16);
    for (int t = 0; t < 4; t++) begin
      for (int l = 0; l < int'(L); l++) begin
        ws[l*16 +: 16]   = 16'($urandom);
        acts[l*16 +: 16] = 16'($urandom);
      end
      send_frame(16, acts, ws, (t == 2) ? 7 : -1, 2, -1, 5'd0);
    end

    // Reset asserted while bit 4 of a frame is presented.
    set_prec(5'd8);
    snap     = ov_cnt;
    in_valid = 1'b1;
    act      = {4{16'h3C00}};
    for (int i = 0; i < 4; i++) begin
      w = 4'($urandom);
      @(posedge clk);
      #1;
    end
    #2 rst = 1'b0;
    #1;
    chk("midrst_busy", longint'(busy), 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_ov", longint'(ov_cnt - snap), 0);
    send_frame(16, {16'h3E00, 16'hBC00, 16'h4000, 16'h3C00},
               {16'h4000, 16'h5800, 16'h3000, 16'h4000}, -1, 0, -1, 5'd0);

    for (int t = 0; t < 40 && sb.size() > 0; t++) @(posedge clk);
    #1;
    chk("drain", longint'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
